mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer for one 9-tap (3x3) MAC datapath.
- Computes one output pixel per command: reads cfg_nch consecutive 72-bit weight/feature words from the line/weight buffers, issues each to the MAC, and accumulates the returned 20-bit partial sums onto a bias.
- Presents the result with a valid/ready handshake.
- Sits between the layer-level scheduler (start/cfg) and the MAC + buffers.

Parameters:
- CH_W, 8, width of channel-group count (max 2^CH_W-1 groups per pixel)
- ADDR_W, 10, buffer read address width
- MAC_W, 20, width of MAC partial sum (signed)
- ACC_W, 32, width of accumulator/result (signed), ACC_W > MAC_W

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start_i  in  1  command strobe, sampled in IDLE only
- cfg_nch_i  in  CH_W  number of channel groups (MAC issues) for this pixel
- cfg_base_i  in  ADDR_W  first buffer address
- cfg_bias_i  in  ACC_W  signed bias, initial accumulator value
- busy_o  out  1  high in any state other than IDLE
- buf_rd_en_o  out  1  buffer read enable (buffer has 1-cycle read latency)
- buf_addr_o  out  ADDR_W  buffer read address
- mac_vld_o  out  1  drives MAC vld_i; buf_rd_en_o delayed exactly 1 cycle
- mac_acc_i  in  MAC_W  signed MAC result
- mac_vld_i  in  1  MAC result valid
- res_o  out  ACC_W  signed result
- res_vld_o  out  1  result valid
- res_rdy_i  in  1  result accepted when res_vld_o & res_rdy_i
- done_o  out  1  one-cycle pulse on the result handshake

Behaviour:
- Reset values: all outputs 0, state IDLE, counters and accumulator 0. Reset mid-operation aborts immediately; nothing is retained.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE:
  - On start_i, latch cfg_*, load acc <= cfg_bias_i, clear issue count ic and return count rc.
  - If cfg_nch_i == 0, go to OUT; otherwise go to ISSUE.
- ISSUE:
  - Each cycle: buf_rd_en_o=1, buf_addr_o=base+ic (mod 2^ADDR_W wrap), ic++.
  - After the cycle with ic == nch-1, go to DRAIN.
  - Exactly nch consecutive read cycles; no bubbles.
- mac_vld_o: registered copy of buf_rd_en_o (1-cycle delay, aligned with buffer data). It does not depend on state, so the final issue still propagates after the move to DRAIN.
- Accumulation:
  - Applies in ISSUE or DRAIN only.
  - Each mac_vld_i: acc <= sat(acc + sign_ext(mac_acc_i)), rc++.
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - mac_vld_i in IDLE or OUT is ignored: no count, no accumulate.
- Timing independence: the controller counts returned valids rather than assuming a fixed MAC latency. Any latency and any gaps between valids are tolerated.
- DRAIN: when rc reaches nch (including the cycle where the final mac_vld_i is accumulated), go to OUT.
- OUT:
  - res_vld_o=1, res_o=acc (after optional ReLU), both held stable until res_rdy_i.
  - On the handshake: done_o=1 for 1 cycle, go to IDLE, res_vld_o=0 in the next cycle.
- start_i while busy_o=1 is ignored; it is not queued.
- Command latency: start_i to res_vld_o = 1 + nch + MAC latency + 1 cycles minimum.
- Back-to-back: start_i may be asserted in the cycle after done_o.

Optional Feature:
- Macro MAC_SEQ_RELU_EN.
- Defined: res_o = (acc < 0) ? 0 : acc.
- Undefined: res_o = acc unmodified.
- Accumulator contents and saturation are identical in both builds.

Test Plan:
- nch=3, base=0x005, bias=10, MAC returns 100,-20,5 -> addresses 0x005,0x006,0x007 on consecutive cycles; mac_vld_o lags rd_en by 1; res_o=95; done_o 1 pulse.
- nch=0, bias=-7, res_rdy_i=1 -> no buffer reads, no mac_vld_o; res_o=-7 (0 with MAC_SEQ_RELU_EN); done_o asserted 2 cycles after start_i.
- base=0x3FE, nch=4 -> addresses 0x3FE,0x3FF,0x000,0x001.
- ACC_W=21, bias=2^20-1, nch=2, MAC returns 0x7FFFF twice -> res_o saturates at 2^20-1; negative case clamps at -2^20.
- res_rdy_i held low 10 cycles in OUT, with start_i pulsed and a stray mac_vld_i injected -> res_o stable, start ignored, stray valid not accumulated; handshake on cycle 11 gives a single done_o.
- rst asserted during ISSUE (ic=2 of 5), then a new start with nch=1 while old MAC valids drain during IDLE -> old valids ignored; new result = bias + one returned value.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Per-pixel sequencer for a 3x3 MAC: issues cfg_nch buffer reads, accumulates returned
// partial sums onto a bias with saturation, presents result via valid/ready. ReLU option: MAC_SEQ_RELU_EN.
module mac_seq_ctrl #(
  parameter int CH_W   = 8,
  parameter int ADDR_W = 10,
  parameter int MAC_W  = 20,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [CH_W-1:0]          cfg_nch_i,
  input  logic [ADDR_W-1:0]        cfg_base_i,
  input  logic signed [ACC_W-1:0]  cfg_bias_i,
  output logic                     busy_o,
  output logic                     buf_rd_en_o,
  output logic [ADDR_W-1:0]        buf_addr_o,
  output logic                     mac_vld_o,
  input  logic signed [MAC_W-1:0]  mac_acc_i,
  input  logic                     mac_vld_i,
  output logic signed [ACC_W-1:0]  res_o,
  output logic                     res_vld_o,
  input  logic                     res_rdy_i,
  output logic                     done_o
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t                   state_q;
  logic [CH_W-1:0]          nch_q, ic_q, rc_q, rc_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W:0]    sum;
  logic                     acc_en;
  logic                     rd_en_q, mac_vld_q, res_vld_q, done_q;
  logic [ADDR_W-1:0]        addr_q;

  // One extra bit of headroom exposes overflow as a mismatch of the top two bits.
  always_comb begin
    acc_en = mac_vld_i && (state_q == S_ISSUE || state_q == S_DRAIN);
    sum    = {acc_q[ACC_W-1], acc_q}
           + {{(ACC_W+1-MAC_W){mac_acc_i[MAC_W-1]}}, mac_acc_i};
    acc_d  = acc_q;
    rc_d   = rc_q;
    if (acc_en) begin
      rc_d = rc_q + CH_W'(1);
      if (sum[ACC_W] != sum[ACC_W-1])
        acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nch_q     <= '0;
      ic_q      <= '0;
      rc_q      <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      mac_vld_q <= 1'b0;
      res_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mac_vld_q <= rd_en_q;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          rd_en_q <= 1'b0;
          if (start_i) begin
            nch_q  <= cfg_nch_i;
            acc_q  <= cfg_bias_i;
            ic_q   <= '0;
            rc_q   <= '0;
            addr_q <= cfg_base_i;
            if (cfg_nch_i == '0) begin
              state_q   <= S_OUT;
              res_vld_q <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              rd_en_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          acc_q <= acc_d;
          rc_q  <= rc_d;
          ic_q  <= ic_q + CH_W'(1);
          if (ic_q == nch_q - CH_W'(1)) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          acc_q <= acc_d;
          rc_q  <= rc_d;
          if (rc_d == nch_q) begin
            state_q   <= S_OUT;
            res_vld_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (res_rdy_i) begin
            res_vld_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign buf_rd_en_o = rd_en_q;
  assign buf_addr_o  = addr_q;
  assign mac_vld_o   = mac_vld_q;
  assign res_vld_o   = res_vld_q;
  assign done_o      = done_q;
`ifdef MAC_SEQ_RELU_EN
  assign res_o = acc_q[ACC_W-1] ? '0 : acc_q;
`else
  assign res_o = acc_q;
`endif
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: 2-cycle MAC model fed from a value table, bus monitor,
// hand-computed expected results (ACC_W=21 so saturation is reachable).
module tb_mac_seq_ctrl;
  localparam int CH_W = 8, ADDR_W = 10, MAC_W = 20, ACC_W = 21;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rdy = 1'b0, inj_vld = 1'b0, clr = 1'b0;
  logic [CH_W-1:0]   cfg_nch = '0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [ACC_W-1:0]  cfg_bias = '0;
  logic [MAC_W-1:0]  inj_val = '0, mac_acc;
  logic              busy, rd_en, mvo, mac_vld, res_vld, done;
  logic [ADDR_W-1:0] addr;
  logic [ACC_W-1:0]  res;

  logic [MAC_W-1:0]  rq [8];
  int                ri = 0, ri_base = 0, cyc = 0;
  logic [1:0]        vpipe = '0;
  logic              rst_e = 1'b1, prev_rd = 1'b0;
  int                n_rd = 0, n_mv = 0, n_done = 0, lag_err = 0, rd_first = -1, rd_last = -1, done_cyc = -1;
  logic [ADDR_W-1:0] alog [8];
  int                n_chk = 0, n_pass = 0;

  mac_seq_ctrl #(.CH_W(CH_W), .ADDR_W(ADDR_W), .MAC_W(MAC_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .cfg_nch_i(cfg_nch), .cfg_base_i(cfg_base),
    .cfg_bias_i(cfg_bias), .busy_o(busy), .buf_rd_en_o(rd_en), .buf_addr_o(addr),
    .mac_vld_o(mvo), .mac_acc_i(mac_acc), .mac_vld_i(mac_vld), .res_o(res),
    .res_vld_o(res_vld), .res_rdy_i(rdy), .done_o(done));

  always #5 clk = ~clk;

  // MAC model: result returns 2 cycles after mac_vld_o, values taken in order from rq.
  assign mac_vld = vpipe[1] | inj_vld;
  assign mac_acc = inj_vld ? inj_val : rq[3'(ri - ri_base)];

  always @(posedge clk) begin
    vpipe <= {vpipe[0], mvo};
    rst_e <= rst;
    cyc   <= cyc + 1;
    if (vpipe[1]) ri <= ri + 1;
  end

  always @(negedge clk) begin
    prev_rd <= rd_en;
    if (clr) begin
      n_rd <= 0; n_mv <= 0; n_done <= 0; lag_err <= 0;
      rd_first <= -1; rd_last <= -1; done_cyc <= -1;
    end else begin
      if (rd_en) begin
        if (n_rd < 8) alog[n_rd[2:0]] <= addr;
        if (rd_first < 0) rd_first <= cyc;
        rd_last <= cyc;
        n_rd    <= n_rd + 1;
      end
      if (mvo) n_mv <= n_mv + 1;
      if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
      if (!rst_e && mvo !== prev_rd) lag_err <= lag_err + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_r(input int v);
`ifdef MAC_SEQ_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic clear_mon();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // Issue one command, wait for the result, optionally stall 10 cycles with disturbances, handshake.
  task automatic run_cmd(input string tag, input int nch, input int base, input int bias,
                         input int expv, input bit hold);
    bit to;
    int unst;
    logic [ACC_W-1:0] r0;
    clear_mon();
    @(negedge clk);
    start = 1'b1; cfg_nch = CH_W'(nch); cfg_base = ADDR_W'(base); cfg_bias = ACC_W'(bias);
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (res_vld) begin to = 1'b0; break; end
      @(negedge clk);
    end
    chk({tag, "_timeout"}, int'(to), 0);
    chk({tag, "_res"}, int'($signed(res)), exp_r(expv));
    if (hold) begin
      r0 = res; unst = 0;
      for (int i = 0; i < 10; i++) begin
        if (i == 2) begin start = 1'b1; cfg_nch = '0; cfg_bias = ACC_W'(99); end
        if (i == 3) start = 1'b0;
        if (i == 5) begin inj_vld = 1'b1; inj_val = MAC_W'(50); end
        if (i == 6) inj_vld = 1'b0;
        @(negedge clk);
        if (res !== r0 || !res_vld || done) unst++;
      end
      chk({tag, "_stable"}, unst, 0);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_vld_drop"}, int'(res_vld), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int sc;
    int ea [4];
    rq = '{default: '0};
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_mac_vld", int'(mvo), 0);
    chk("rst_res_vld", int'(res_vld), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_res", int'($signed(res)), 0);
    rst = 1'b0;

    // 10 + 100 - 20 + 5
    rq = '{20'd100, -20'sd20, 20'd5, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0}; ri_base = ri;
    run_cmd("t1", 3, 'h005, 10, 95, 1'b0);
    chk("t1_nrd", n_rd, 3);
    chk("t1_a0", int'(alog[0]), 'h005);
    chk("t1_a1", int'(alog[1]), 'h006);
    chk("t1_a2", int'(alog[2]), 'h007);
    chk("t1_consec", rd_last - rd_first, 2);
    chk("t1_nmv", n_mv, 3);
    chk("t1_lag", lag_err, 0);
    chk("t1_ndone", n_done, 1);

    // nch=0: straight to OUT, done two cycles after start
    clear_mon();
    rdy = 1'b1;
    @(negedge clk);
    start = 1'b1; cfg_nch = '0; cfg_base = '0; cfg_bias = ACC_W'(-7); sc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("t2_res_vld", int'(res_vld), 1);
    chk("t2_res", int'($signed(res)), exp_r(-7));
    @(negedge clk);
    chk("t2_done", int'(done), 1);
    rdy = 1'b0;
    @(posedge clk); #1;
    chk("t2_nrd", n_rd, 0);
    chk("t2_nmv", n_mv, 0);
    chk("t2_done_lat", done_cyc - sc, 2);

    // address wrap
    rq = '{20'd1, 20'd2, 20'd3, 20'd4, 20'd0, 20'd0, 20'd0, 20'd0}; ri_base = ri;
    run_cmd("t3", 4, 'h3FE, 0, 10, 1'b0);
    ea = '{'h3FE, 'h3FF, 'h000, 'h001};
    chk("t3_nrd", n_rd, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_a%0d", i), int'(alog[i]), ea[i]);
    chk("t3_lag", lag_err, 0);

    // saturation at both rails of a 21-bit accumulator
    rq = '{20'h7FFFF, 20'h7FFFF, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0}; ri_base = ri;
    run_cmd("t4_pos", 2, 0, 1048575, 1048575, 1'b0);
    rq = '{20'h80000, 20'h80000, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0}; ri_base = ri;
    run_cmd("t4_neg", 2, 0, -1048576, -1048576, 1'b0);

    // stall in OUT with stray start and stray MAC valid: 3 + 4
    rq = '{20'd4, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0}; ri_base = ri;
    run_cmd("t5", 1, 'h020, 3, 7, 1'b1);
    chk("t5_ndone", n_done, 1);
    @(negedge clk);
    chk("t5_idle", int'(busy), 0);

    // reset during ISSUE (ic=2 of 5); old valids drain while idle
    clear_mon();
    rq = '{default: 20'd500}; ri_base = ri;
    @(negedge clk);
    start = 1'b1; cfg_nch = CH_W'(5); cfg_base = '0; cfg_bias = ACC_W'(1000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_rd", int'(rd_en), 0);
    repeat (4) @(negedge clk);
    chk("t6_idle_busy", int'(busy), 0);
    chk("t6_idle_vld", int'(res_vld), 0);
    @(posedge clk); #1;
    rq = '{20'd7, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0}; ri_base = ri;
    run_cmd("t6", 1, 'h010, 20, 27, 1'b0);
    chk("t6_nrd", n_rd, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
